// File: rtl/cache_fill_fsm_pkg.sv
// Shared definitions for the cache miss-fill logic: FSM encoding and
// block/word address geometry.
package cache_fill_fsm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  localparam logic [15:0] BLOCK_OFFSET_MASK = 16'hFFF0;
  localparam int          WORD_BYTES        = 2;

endpackage

// File: rtl/cache_fill_fsm_dff.sv
// Enabled D flip-flop with synchronous active-high reset to a
// parameterised value.
module cache_fill_fsm_dff #(
  parameter int             W       = 1,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      q_o <= RST_VAL;
    end else if (en_i) begin
      q_o <= d_i;
    end
  end

endmodule

// File: rtl/cache_fill_fsm_fill_counter.sv
// Word counter for one side of a block fill: counts 0..max then raises a
// sticky done flag instead of wrapping, so "all words seen" is one more state.
module cache_fill_fsm_fill_counter #(
  parameter int CNT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             done_o
);

  logic             last;
  logic             step;
  logic [CNT_W-1:0] cnt_d;
  logic             done_d;

  assign last = &cnt_o;
  assign step = en_i & ~done_o;

  always_comb begin
    cnt_d  = cnt_o;
    done_d = done_o;
    if (clr_i) begin
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (step) begin
      // Hold at the top value and flag saturation rather than wrapping.
      if (last) begin
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_o + CNT_W'(1);
      end
    end
  end

  cache_fill_fsm_dff #(.W(CNT_W), .RST_VAL('0)) u_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (1'b1),
    .d_i   (cnt_d),
    .q_o   (cnt_o)
  );

  cache_fill_fsm_dff #(.W(1), .RST_VAL(1'b0)) u_done (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (1'b1),
    .d_i   (done_d),
    .q_o   (done_o)
  );

endmodule

// File: rtl/cache_fill_fsm.sv
// Miss-fill responder: fetches a 16-byte block word by word from pipelined
// memory, strobes each returned word into the data array, then writes the tag.
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter int ADDR_W          = 16,
  parameter int WORDS_PER_BLOCK = 8,
  parameter int CNT_W           = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  output logic              fsm_busy,
  output logic              mem_en,
  output logic [ADDR_W-1:0] memory_address,
  output logic [ADDR_W-1:0] cache_word_addr,
  output logic [CNT_W-1:0]  fill_word,
  output logic              write_data_array,
  output logic              write_tag_array
);

  fill_state_e       state_q;
  fill_state_e       state_d;
  logic              accept;
  logic              issue_done;
  logic              ret_done;
  logic              ret_last;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  ret_cnt;
  logic [ADDR_W-1:0] base_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign ret_last = (ret_cnt == CNT_W'(WORDS_PER_BLOCK - 1));

  always_comb begin
    state_d          = state_q;
    accept           = 1'b0;
    fsm_busy         = 1'b0;
    mem_en           = 1'b0;
    write_data_array = 1'b0;
    write_tag_array  = 1'b0;
    case (state_q)
      IDLE: begin
        // Stall in the same cycle the miss is seen, before the fill starts.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          accept  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        fsm_busy = 1'b1;
        mem_en   = ~issue_done;
        if (memory_data_valid && !ret_done) begin
          write_data_array = 1'b1;
          if (ret_last) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  cache_fill_fsm_dff #(.W(ADDR_W), .RST_VAL('0)) u_base (
    .clk_i (clk),
    .rst_i (rst),
    .en_i  (accept),
    .d_i   (miss_address & ADDR_W'(BLOCK_OFFSET_MASK)),
    .q_o   (base_q)
  );

  cache_fill_fsm_fill_counter #(.CNT_W(CNT_W)) u_issue_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (accept),
    .en_i   (mem_en),
    .cnt_o  (issue_cnt),
    .done_o (issue_done)
  );

  cache_fill_fsm_fill_counter #(.CNT_W(CNT_W)) u_ret_cnt (
    .clk_i  (clk),
    .rst_i  (rst),
    .clr_i  (accept),
    .en_i   (write_data_array),
    .cnt_o  (ret_cnt),
    .done_o (ret_done)
  );

  // Word offsets stay inside bits [3:0], so the add never carries into the tag.
  assign memory_address  = base_q + ADDR_W'(WORD_BYTES) * ADDR_W'(issue_cnt);
  assign cache_word_addr = base_q + ADDR_W'(WORD_BYTES) * ADDR_W'(ret_cnt);
  assign fill_word       = ret_cnt;

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Self-checking bench for cache_fill_fsm: a fixed-latency memory model, a
// per-cycle behavioural fill model, and directed fill scenarios.
module tb_cache_fill_fsm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_detected = 1'b0;
  logic [15:0] miss_address = '0;
  logic        memory_data_valid = 1'b0;
  logic        fsm_busy;
  logic        mem_en;
  logic [15:0] memory_address;
  logic [15:0] cache_word_addr;
  logic [2:0]  fill_word;
  logic        write_data_array;
  logic        write_tag_array;

  cache_fill_fsm dut (
    .clk               (clk),
    .rst               (rst),
    .miss_detected     (miss_detected),
    .miss_address      (miss_address),
    .memory_data_valid (memory_data_valid),
    .fsm_busy          (fsm_busy),
    .mem_en            (mem_en),
    .memory_address    (memory_address),
    .cache_word_addr   (cache_word_addr),
    .fill_word         (fill_word),
    .write_data_array  (write_data_array),
    .write_tag_array   (write_tag_array)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  int lat          = 4;
  int ret_q[$];

  // Behavioural model of one fill: whether a block is in flight, its base,
  // and how many words have been requested / returned.
  bit          m_active   = 1'b0;
  logic [15:0] m_base     = '0;
  int          m_issued   = 0;
  int          m_returned = 0;

  // Event logs for the directed checks
  int          req_cyc[$];
  logic [15:0] req_addr[$];
  int          wr_cyc[$];
  logic [15:0] wr_addr[$];
  int          wr_word[$];
  int          tag_cyc[$];
  bit          busy_log[int];
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    while (ret_q.size() > 0 && ret_q[0] < cyc) void'(ret_q.pop_front());
    memory_data_valid = (ret_q.size() > 0 && ret_q[0] == cyc);
    if (memory_data_valid) void'(ret_q.pop_front());
  endtask

  task automatic run_until(input int n);
    while (cyc < n) step();
  endtask

  task automatic clear_logs();
    req_cyc.delete();  req_addr.delete();
    wr_cyc.delete();   wr_addr.delete();   wr_word.delete();
    tag_cyc.delete();  busy_log.delete();
  endtask

  // Compare process: every cycle, away from the rising edge
  always @(negedge clk) begin
    logic        e_busy, e_men, e_wda, e_wta;
    logic [15:0] e_maddr, e_caddr;
    e_busy  = m_active || miss_detected;
    e_men   = m_active && (m_issued < 8);
    e_maddr = m_base + 16'(2 * m_issued);
    e_wda   = m_active && memory_data_valid;
    e_wta   = e_wda && (m_returned == 7);
    e_caddr = m_base + 16'(2 * m_returned);

    chk($sformatf("busy@%0d", cyc), 32'(fsm_busy), 32'(e_busy));
    chk($sformatf("mem_en@%0d", cyc), 32'(mem_en), 32'(e_men));
    chk($sformatf("wda@%0d", cyc), 32'(write_data_array), 32'(e_wda));
    chk($sformatf("wta@%0d", cyc), 32'(write_tag_array), 32'(e_wta));
    if (e_men) chk($sformatf("mem_addr@%0d", cyc), 32'(memory_address), 32'(e_maddr));
    if (e_wda) begin
      chk($sformatf("cache_addr@%0d", cyc), 32'(cache_word_addr), 32'(e_caddr));
      chk($sformatf("fill_word@%0d", cyc), 32'(fill_word), 32'(m_returned));
    end

    busy_log[cyc] = fsm_busy;
    if (mem_en) begin
      req_cyc.push_back(cyc);
      req_addr.push_back(memory_address);
      if (!rst) ret_q.push_back(cyc + lat);
    end
    if (write_data_array) begin
      wr_cyc.push_back(cyc);
      wr_addr.push_back(cache_word_addr);
      wr_word.push_back(int'(fill_word));
    end
    if (write_tag_array) tag_cyc.push_back(cyc);

    if (rst) begin
      m_active = 1'b0; m_base = '0; m_issued = 0; m_returned = 0;
    end else if (!m_active) begin
      if (miss_detected) begin
        m_active = 1'b1; m_base = miss_address & 16'hFFF0;
        m_issued = 0;    m_returned = 0;
      end
    end else begin
      if (m_issued < 8) m_issued++;
      if (memory_data_valid) begin
        m_returned++;
        if (m_returned == 8) m_active = 1'b0;
      end
    end
  end

  // Checks one complete fill from the logs, miss presented on cycle t0.
  task automatic check_fill(input string tag, input logic [15:0] base, input int t0, input int l);
    chk({tag, " req_count"}, 32'(req_cyc.size()), 32'd8);
    chk({tag, " wr_count"}, 32'(wr_cyc.size()), 32'd8);
    chk({tag, " tag_count"}, 32'(tag_cyc.size()), 32'd1);
    exp_q.delete();
    for (int i = 0; i < 8; i++) exp_q.push_back(base + 16'(2 * i));
    for (int i = 0; i < 8 && i < req_cyc.size(); i++) begin
      chk($sformatf("%s req_cyc[%0d]", tag, i), 32'(req_cyc[i]), 32'(t0 + 1 + i));
      chk($sformatf("%s req_addr[%0d]", tag, i), 32'(req_addr[i]), 32'(exp_q[i]));
    end
    for (int i = 0; i < 8 && i < wr_cyc.size(); i++) begin
      chk($sformatf("%s wr_cyc[%0d]", tag, i), 32'(wr_cyc[i]), 32'(t0 + l + 1 + i));
      chk($sformatf("%s wr_addr[%0d]", tag, i), 32'(wr_addr[i]), 32'(exp_q[i]));
      chk($sformatf("%s wr_word[%0d]", tag, i), 32'(wr_word[i]), 32'(i));
    end
    if (tag_cyc.size() > 0) chk({tag, " tag_cyc"}, 32'(tag_cyc[0]), 32'(t0 + l + 8));
    for (int c = t0; c <= t0 + l + 8; c++)
      chk($sformatf("%s busy_hold@%0d", tag, c - t0), 32'(busy_log.exists(c) ? busy_log[c] : 1'b0), 32'd1);
  endtask

  task automatic present_miss(input logic [15:0] a, output int t0);
    miss_detected = 1'b1;
    miss_address  = a;
    t0 = cyc;
    step();
    miss_detected = 1'b0;
    miss_address  = '0;
  endtask

  initial begin
    int t0, t1, bad;

    // Reset held mid-idle for two cycles
    step(); step();
    rst = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #2;
    chk("rst busy",   32'(fsm_busy), 32'd0);
    chk("rst mem_en", 32'(mem_en), 32'd0);
    chk("rst wda",    32'(write_data_array), 32'd0);
    chk("rst wta",    32'(write_tag_array), 32'd0);
    chk("rst maddr",  32'(memory_address), 32'd0);
    chk("rst caddr",  32'(cache_word_addr), 32'd0);
    chk("rst fword",  32'(fill_word), 32'd0);
    step(); step();

    // Single fill, latency 4
    clear_logs();
    present_miss(16'h1234, t0);
    run_until(t0 + 14);
    check_fill("single", 16'h1230, t0, 4);
    if (req_addr.size() == 8) begin
      chk("single req0 lit", 32'(req_addr[0]), 32'h1230);
      chk("single req7 lit", 32'(req_addr[7]), 32'h123E);
    end
    if (tag_cyc.size() == 1) chk("single tag lit", 32'(tag_cyc[0] - t0), 32'd12);
    chk("single busy@13", 32'(busy_log.exists(t0 + 13) ? busy_log[t0 + 13] : 1'b1), 32'd0);
    step(); step();

    // Miss presented during a fill must be ignored
    clear_logs();
    present_miss(16'h0040, t0);
    run_until(t0 + 3);
    miss_detected = 1'b1;
    miss_address  = 16'hABCD;
    step();
    miss_detected = 1'b0;
    miss_address  = '0;
    run_until(t0 + 16);
    check_fill("ignored", 16'h0040, t0, 4);
    bad = 0;
    foreach (req_addr[i]) if (req_addr[i] < 16'h0040 || req_addr[i] > 16'h004E) bad++;
    foreach (wr_addr[i])  if (wr_addr[i]  < 16'h0040 || wr_addr[i]  > 16'h004E) bad++;
    chk("ignored out_of_range", 32'(bad), 32'd0);

    // Back-to-back: second miss on the first cycle after completion
    clear_logs();
    present_miss(16'h3008, t0);
    run_until(t0 + 13);
    check_fill("b2b first", 16'h3000, t0, 4);
    clear_logs();
    present_miss(16'h2000, t1);
    chk("b2b second t", 32'(t1 - t0), 32'd13);
    run_until(t1 + 14);
    check_fill("b2b second", 16'h2000, t1, 4);
    if (wr_addr.size() == 8) chk("b2b wr7 lit", 32'(wr_addr[7]), 32'h200E);

    // Reset in the middle of a fill
    step(); step();
    clear_logs();
    present_miss(16'h0100, t0);
    run_until(t0 + 6);
    rst = 1'b1;
    ret_q.delete();
    step();
    rst = 1'b0;
    clear_logs();
    run_until(t0 + 17);
    chk("midrst req_count", 32'(req_cyc.size()), 32'd0);
    chk("midrst wr_count",  32'(wr_cyc.size()), 32'd0);
    chk("midrst tag_count", 32'(tag_cyc.size()), 32'd0);
    bad = 0;
    for (int c = t0 + 7; c < t0 + 17; c++) if (!busy_log.exists(c) || busy_log[c]) bad++;
    chk("midrst busy", 32'(bad), 32'd0);

    // Fast memory, latency 1, block at the top of the address space
    lat = 1;
    clear_logs();
    present_miss(16'hFFF8, t0);
    run_until(t0 + 12);
    check_fill("lat1", 16'hFFF0, t0, 1);
    if (req_addr.size() == 8) chk("lat1 req7 lit", 32'(req_addr[7]), 32'hFFFE);
    if (wr_cyc.size() == 8)   chk("lat1 wr0 lit", 32'(wr_cyc[0] - t0), 32'd2);
    if (tag_cyc.size() == 1)  chk("lat1 tag lit", 32'(tag_cyc[0] - t0), 32'd9);

    step(); step();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
